rs_enc_frame_ctrl: RTL and testbench
====================================

# rs_enc_frame_ctrl

Frame sequencer placed in front of the multi-width RS encoder wrapper (symbol widths 3–8). It takes message symbols from an upstream valid/ready stream and latches the symbol width once per frame. It delivers exactly K symbols per frame with a start-of-frame marker, then blocks new input until the encoder signals end-of-codeword. It also reports completion, configuration errors and watchdog timeouts.

## Interface
- TIMEOUT, 1023: max cycles from last message beat to encoder `enc_eop` before abort (10-bit counter).
- SETUP_CYC, 2: cycles `enc_sym_width` is held stable before the first `enc_din_val` of a frame (covers the encoder's internal width register).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_sym_width  in  4  requested symbol width; sampled only when leaving IDLE.
- s_valid  in  1  upstream message symbol valid.
- s_ready  out  1  upstream ready; combinational, high only in FEED.
- s_data  in  8  message symbol; bits above width are ignored and forwarded as zero.
- enc_sym_width  out  4  width driven to the encoder.
- enc_din_val  out  1  symbol strobe to the encoder.
- enc_din_sop  out  1  first message symbol of a frame.
- enc_din  out  8  symbol to the encoder.
- enc_eop  in  1  encoder output end-of-codeword.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when a codeword completes.
- cfg_err  out  1  sticky; unsupported width requested. Cleared by a valid width in IDLE.
- tmo_err  out  1  one-cycle pulse on watchdog abort.
- frame_cnt  out  16  completed frames; wraps 0xFFFF→0.

## Operation
- K per width: 3→3, 4→11, 5→23, 6→55, 7→111, 8→223. Widths outside 3..8 are unsupported.
- **IDLE**
  - If `s_valid` and `cfg_sym_width` is supported: latch width into `enc_sym_width`, load K, go to SETUP.
  - If `s_valid` and width is unsupported: set `cfg_err`, stay in IDLE. `enc_sym_width` is unchanged and `s_ready` stays 0.
- **SETUP**: count SETUP_CYC cycles, then go to FEED.
- **FEED**
  - `s_ready` = 1. Each `s_valid & s_ready` beat is one accept.
  - On an accept, register `enc_din_val` = 1 and `enc_din` = `s_data` masked to the width.
  - `enc_din_sop` = 1 only on the first accept of the frame.
  - Gaps in `s_valid` pass through as gaps in `enc_din_val`.
  - After the K-th accept go to WAIT_EOP and clear the watchdog.
- **WAIT_EOP**
  - On `enc_eop`: pulse `frame_done`, increment `frame_cnt`, go to IDLE.
  - If the watchdog reaches TIMEOUT without `enc_eop`: pulse `tmo_err`, set `enc_sym_width` = 0 (encoder fully gated), go to IDLE.
- `enc_eop` outside WAIT_EOP is ignored.
- `enc_sym_width` never changes in SETUP, FEED or WAIT_EOP.
- Symbol counter is 8 bits and is compared against K−1. No wrap occurs within a frame.

## Timing
- Reset values: all outputs 0, state IDLE. `s_ready` = 0, `enc_sym_width` = 0, `frame_cnt` = 0.
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is discarded.
- `enc_din*` outputs are registered, so the accept at edge t appears as `enc_din_val` during cycle t+1.
- `s_valid` seen in IDLE at edge t0:
  - SETUP occupies t0+1 .. t0+SETUP_CYC.
  - `s_ready` is first high in cycle t0+SETUP_CYC+1.
  - The IDLE cycle does not consume a symbol.
- After the K-th accept, `s_ready` drops in the next cycle.
- `enc_eop` and the watchdog expiring in the same cycle: `enc_eop` wins, giving a `frame_done` pulse and no `tmo_err`.
- `frame_done` and the IDLE→SETUP decision for the next frame never occur in the same cycle. The next frame starts at the earliest one cycle after `frame_done`.
- `cfg_err` sets in the cycle after the offending sample and holds until a supported width is accepted from IDLE.

## Test plan
- **Width 3, contiguous `s_valid`, symbols 1,2,3**
  - `enc_din_val` is high for exactly 3 cycles carrying 1,2,3, with `enc_din_sop` on symbol 1.
  - `enc_sym_width` = 3 at least 2 cycles before the first strobe.
  - `enc_eop` at any later cycle gives `frame_done`, and `frame_cnt` = 1.
- **Width 8, 223 symbols with `s_valid` low every 4th cycle**
  - Exactly 223 strobes, and `enc_din` equals `s_data`.
  - `s_ready` = 0 from the cycle after the 223rd accept until the next frame's FEED.
- **Width 5, `s_data` = 8'hFF**: `enc_din` = 8'h1F on all 23 strobes.
- **`cfg_sym_width` = 9 with `s_valid` high**
  - `cfg_err` = 1, `s_ready` stays 0, no strobes.
  - Changing to 4 clears `cfg_err` and starts an 11-symbol frame.
- **No `enc_eop` after a width-4 frame**
  - `tmo_err` pulses at the 1023rd WAIT_EOP cycle, `enc_sym_width` → 0, `frame_cnt` stays unchanged.
  - With `enc_eop` driven exactly in the expiry cycle instead: `frame_done` only.
- **`rst_n` low for 1 cycle at symbol 50 of a width-6 frame**
  - All outputs return to 0.
  - The next frame starts with `enc_din_sop` and delivers a full 55 symbols.

Source files
------------

// File: rtl/rs_enc_frame_ctrl.sv
// Frame sequencer in front of the multi-width RS encoder wrapper.
// Latches width per frame, feeds K symbols, waits for end-of-codeword.
module rs_enc_frame_ctrl #(
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned SETUP_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cfg_sym_width_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [7:0]  s_data_i,
  output logic [3:0]  enc_sym_width_o,
  output logic        enc_din_val_o,
  output logic        enc_din_sop_o,
  output logic [7:0]  enc_din_o,
  input  logic        enc_eop_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        cfg_err_o,
  output logic        tmo_err_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned SC_W = $clog2(SETUP_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FEED,
    WAIT_EOP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  width_q, width_d;
  logic [7:0]  kmax_q, kmax_d;
  logic [7:0]  sym_q, sym_d;
  logic [SC_W-1:0] setup_q, setup_d;
  logic [9:0]  wdog_q, wdog_d;
  logic        val_q, val_d;
  logic        sop_q, sop_d;
  logic [7:0]  din_q, din_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;

  logic        cfg_ok;
  logic [7:0]  cfg_kmax;
  logic [7:0]  mask;

  // K-1 for the requested width; unsupported widths flag cfg_ok low
  always_comb begin
    cfg_ok   = 1'b1;
    cfg_kmax = 8'd0;
    case (cfg_sym_width_i)
      4'd3:    cfg_kmax = 8'd2;
      4'd4:    cfg_kmax = 8'd10;
      4'd5:    cfg_kmax = 8'd22;
      4'd6:    cfg_kmax = 8'd54;
      4'd7:    cfg_kmax = 8'd110;
      4'd8:    cfg_kmax = 8'd222;
      default: cfg_ok   = 1'b0;
    endcase
  end

  always_comb begin
    mask = 8'h00;
    case (width_q)
      4'd3:    mask = 8'h07;
      4'd4:    mask = 8'h0F;
      4'd5:    mask = 8'h1F;
      4'd6:    mask = 8'h3F;
      4'd7:    mask = 8'h7F;
      4'd8:    mask = 8'hFF;
      default: mask = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    kmax_d    = kmax_q;
    sym_d     = sym_q;
    setup_d   = setup_q;
    wdog_d    = wdog_q;
    val_d     = 1'b0;
    sop_d     = 1'b0;
    din_d     = din_q;
    done_d    = 1'b0;
    cfg_err_d = cfg_err_q;
    tmo_d     = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        // no new frame in the frame_done cycle
        if (s_valid_i && !done_q) begin
          if (cfg_ok) begin
            width_d   = cfg_sym_width_i;
            kmax_d    = cfg_kmax;
            sym_d     = 8'd0;
            setup_d   = '0;
            cfg_err_d = 1'b0;
            state_d   = SETUP;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (setup_q == SC_W'(SETUP_CYC - 1)) begin
          state_d = FEED;
        end else begin
          setup_d = setup_q + 1'b1;
        end
      end
      FEED: begin
        if (s_valid_i) begin
          val_d = 1'b1;
          sop_d = (sym_q == 8'd0);
          din_d = s_data_i & mask;
          if (sym_q == kmax_q) begin
            wdog_d  = 10'd0;
            state_d = WAIT_EOP;
          end else begin
            sym_d = sym_q + 8'd1;
          end
        end
      end
      WAIT_EOP: begin
        if (enc_eop_i) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end else if (wdog_q == 10'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          width_d = 4'd0;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      width_q   <= 4'd0;
      kmax_q    <= 8'd0;
      sym_q     <= 8'd0;
      setup_q   <= '0;
      wdog_q    <= 10'd0;
      val_q     <= 1'b0;
      sop_q     <= 1'b0;
      din_q     <= 8'd0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      kmax_q    <= kmax_d;
      sym_q     <= sym_d;
      setup_q   <= setup_d;
      wdog_q    <= wdog_d;
      val_q     <= val_d;
      sop_q     <= sop_d;
      din_q     <= din_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready_o       = (state_q == FEED);
  assign busy_o          = (state_q != IDLE);
  assign enc_sym_width_o = width_q;
  assign enc_din_val_o   = val_q;
  assign enc_din_sop_o   = sop_q;
  assign enc_din_o       = din_q;
  assign frame_done_o    = done_q;
  assign cfg_err_o       = cfg_err_q;
  assign tmo_err_o       = tmo_q;
  assign frame_cnt_o     = cnt_q;

endmodule

// File: tb/tb_rs_enc_frame_ctrl.sv
// Directed bench for rs_enc_frame_ctrl.
// Accepted symbols go to a scoreboard queue, popped on enc_din_val.
module tb_rs_enc_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cfg_sym_width = 4'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'd0;
  logic [3:0]  enc_sym_width;
  logic        enc_din_val;
  logic        enc_din_sop;
  logic [7:0]  enc_din;
  logic        enc_eop = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;
  logic        tmo_err;
  logic [15:0] frame_cnt;

  rs_enc_frame_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_sym_width_i (cfg_sym_width),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready),
    .s_data_i        (s_data),
    .enc_sym_width_o (enc_sym_width),
    .enc_din_val_o   (enc_din_val),
    .enc_din_sop_o   (enc_din_sop),
    .enc_din_o       (enc_din),
    .enc_eop_i       (enc_eop),
    .busy_o          (busy),
    .frame_done_o    (frame_done),
    .cfg_err_o       (cfg_err),
    .tmo_err_o       (tmo_err),
    .frame_cnt_o     (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic [3:0] w;
  } exp_t;

  exp_t       sb[$];
  exp_t       me;
  int         n_chk = 0;
  int         n_fail = 0;
  int         strobes = 0;
  int         stable = 0;
  int         exp_cnt = 0;
  int         base = 0;
  logic [3:0] prev_w = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (enc_sym_width == prev_w) stable++;
    else stable = 0;
    prev_w = enc_sym_width;
    if (enc_din_val === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        me = sb.pop_front();
        chk("enc_din", enc_din, me.d);
        chk("enc_din_sop", enc_din_sop, me.sop);
        if (me.sop) begin
          chk("width_at_sop", enc_sym_width, me.w);
          chk("width_setup_hold", stable >= 2, 1);
        end
      end
    end
  end

  task automatic feed(input logic [3:0] w, input int n,
                      input int mode, input bit gaps);
    int idx;
    int cyc;
    logic [7:0] d;
    logic [7:0] m;
    exp_t e;
    idx = 0;
    cyc = 0;
    m = 8'((1 << w) - 1);
    cfg_sym_width = w;
    while (idx < n) begin
      case (mode)
        0:       d = 8'(idx + 1);
        1:       d = 8'($urandom);
        default: d = 8'hFF;
      endcase
      s_valid = gaps ? ((cyc % 4) != 3) : 1'b1;
      s_data = d;
      @(negedge clk);
      if (s_valid && s_ready) begin
        e.d = d & m;
        e.sop = (idx == 0);
        e.w = w;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 4 * n + 50) begin
        chk("feed_budget", 32'd0, 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_data = 8'd0;
  endtask

  task automatic drain(input int b, input int n);
    repeat (3) begin
      @(negedge clk);
      chk("s_ready_wait", s_ready, 0);
    end
    chk("strobe_count", strobes - b, n);
    chk("sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic give_eop();
    enc_eop = 1'b1;
    @(posedge clk);
    #1;
    enc_eop = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("frame_done", frame_done, 1);
    chk("frame_cnt", frame_cnt, exp_cnt);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
    chk("busy_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_width", enc_sym_width, 0);
    chk("rst_din_val", enc_din_val, 0);
    chk("rst_din_sop", enc_din_sop, 0);
    chk("rst_din", enc_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // width 3, symbols 1,2,3
    base = strobes;
    feed(4'd3, 3, 0, 1'b0);
    @(negedge clk);
    chk("ready_drop_w3", s_ready, 0);
    chk("busy_wait", busy, 1);
    @(posedge clk);
    #1;
    drain(base, 3);
    give_eop();

    // width 8, gaps every 4th cycle
    base = strobes;
    feed(4'd8, 223, 1, 1'b1);
    drain(base, 223);

    // eop with s_valid already high: next frame waits past frame_done
    cfg_sym_width = 4'd5;
    s_valid = 1'b1;
    s_data = 8'hFF;
    enc_eop = 1'b1;
    @(posedge clk);
    #1;
    enc_eop = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("frame_done_w8", frame_done, 1);
    chk("frame_cnt_w8", frame_cnt, exp_cnt);
    chk("ready_in_done", s_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ready_before_feed", s_ready, 0);
    end
    @(posedge clk);
    #1;
    chk("ready_feed_start", s_ready, 1);

    // width 5, all-ones data masked
    base = strobes;
    feed(4'd5, 23, 2, 1'b0);
    drain(base, 23);
    chk("width5_hold", enc_sym_width, 5);
    give_eop();

    // unsupported width
    base = strobes;
    cfg_sym_width = 4'd9;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("cfg_err_set", cfg_err, 1);
      chk("cfg_err_ready", s_ready, 0);
      chk("cfg_err_busy", busy, 0);
    end
    chk("cfg_err_width", enc_sym_width, 5);
    chk("cfg_err_strobes", strobes - base, 0);
    @(posedge clk);
    #1;

    // width 4 recovers, then no eop: watchdog
    base = strobes;
    feed(4'd4, 11, 1, 1'b0);
    chk("cfg_err_clear", cfg_err, 0);
    for (int i = 2; i <= 1023; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("strobes_w4", strobes - base, 11);
    chk("tmo_early", tmo_err, 0);
    chk("busy_before_tmo", busy, 1);
    @(negedge clk);
    chk("tmo_pulse", tmo_err, 1);
    chk("tmo_width", enc_sym_width, 0);
    chk("tmo_cnt", frame_cnt, exp_cnt);
    chk("tmo_no_done", frame_done, 0);
    chk("tmo_busy", busy, 0);
    @(negedge clk);
    chk("tmo_pulse_end", tmo_err, 0);
    @(posedge clk);
    #1;

    // eop exactly in the expiry cycle
    base = strobes;
    feed(4'd3, 3, 1, 1'b0);
    for (int i = 2; i <= 1023; i++) begin
      @(posedge clk);
      #1;
    end
    enc_eop = 1'b1;
    @(posedge clk);
    #1;
    enc_eop = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("expiry_done", frame_done, 1);
    chk("expiry_no_tmo", tmo_err, 0);
    chk("expiry_cnt", frame_cnt, exp_cnt);
    chk("expiry_width", enc_sym_width, 3);
    @(negedge clk);
    chk("expiry_no_tmo2", tmo_err, 0);
    chk("strobes_exp", strobes - base, 3);
    @(posedge clk);
    #1;

    // reset at symbol 50 of width 6
    base = strobes;
    feed(4'd6, 50, 1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_val", enc_din_val, 0);
    chk("mid_rst_sop", enc_din_sop, 0);
    chk("mid_rst_din", enc_din, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_width", enc_sym_width, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_strobes", strobes - base, 50);
    chk("mid_rst_sb", sb.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    base = strobes;
    feed(4'd6, 55, 1, 1'b0);
    drain(base, 55);
    give_eop();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
